inst_loader: RTL



---
 rtl/inst_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction loader for the single-cycle LEGv8 core.
// Receives a byte stream (16-bit LE word count, then 4*N LE payload bytes),
// writes assembled words into instruction memory, holds the core in reset
// until the program is loaded, then releases it and idles until rst_n.
// Optional feature macro: INST_LOADER_CSUM_EN appends an XOR checksum byte
// to the stream that must match the payload or the load aborts.
module inst_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_LEN0 = 3'd0;
    localparam logic [2:0] S_LEN1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef INST_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // State entered once the payload (or an empty count) has been consumed.
`ifdef INST_LOADER_CSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_WAIT;
`endif

    // Largest word count that fits in instruction memory.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [7:0]      len_lo;
    logic [16:0]     n_words;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_cnt;
    logic [23:0]     byte_buf;
    logic            acc;
    logic [16:0]     n_in;
    logic            last_word;

`ifdef INST_LOADER_CSUM_EN
    logic [7:0]      csum;
`endif

    assign acc       = rx_valid && rx_ready;
    assign n_in      = {1'b0, rx_data, len_lo};
    assign last_word = (17'(word_cnt) + 17'd1) == n_words;

    // Next-state decode; RUN and ERR are terminal until rst_n.
    always_comb begin
        state_nx = state;
        case (state)
            S_LEN0: if (acc) state_nx = S_LEN1;
            S_LEN1: begin
                if (acc) begin
                    if (n_in > MAX_WORDS)
                        state_nx = S_ERR;
                    else if (n_in == 17'd0)
                        state_nx = S_AFTER_DATA;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: if (acc && byte_cnt == 2'd3 && last_word) state_nx = S_AFTER_DATA;
`ifdef INST_LOADER_CSUM_EN
            S_CSUM: if (acc) state_nx = (rx_data == csum) ? S_WAIT : S_ERR;
`endif
            S_WAIT: state_nx = S_RUN;
            S_RUN:  state_nx = S_RUN;
            S_ERR:  state_nx = S_ERR;
            default: state_nx = S_ERR;
        endcase
    end

    // State register and status outputs, registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LEN0;
            rx_ready   <= 1'b0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            rx_ready   <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
`ifdef INST_LOADER_CSUM_EN
                          (state_nx == S_CSUM) ||
`endif
                          (state_nx == S_DATA);
            core_rst_n <= (state_nx == S_RUN);
            done       <= (state_nx == S_RUN);
            err        <= (state_nx == S_ERR);
        end
    end

    // Count capture, byte assembly and the one-cycle memory write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo     <= '0;
            n_words    <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            byte_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (acc && state == S_LEN0)
                len_lo <= rx_data;
            if (acc && state == S_LEN1)
                n_words <= n_in;
            if (acc && state == S_DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                byte_buf <= {rx_data, byte_buf[23:8]};
                if (byte_cnt == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_cnt[ADDR_W-1:0];
                    imem_wdata <= {rx_data, byte_buf};
                    word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                end
            end
        end
    end

`ifdef INST_LOADER_CSUM_EN
    // Running XOR over payload bytes only; count bytes are excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= '0;
        else if (acc && state == S_DATA)
            csum <= csum ^ rx_data;
    end
`endif

endmodule
